ysyx_22040895_lsu: RTL and testbench
====================================

Name: ysyx_22040895_lsu

Overview:
- Multi-cycle load/store unit directly downstream of the execute stage.
- Consumes the EXU result as the effective address and the EXU store-data output as write data.
- Performs one 64-bit-bus data-memory transaction per accepted request, with a request/grant and response handshake.
- Returns aligned, sign- or zero-extended load data, or a store acknowledge, to writeback.

Parameters:
- ADDR_W, 64: address width.
- DATA_W, 64: data bus width; must be 64 (8 byte lanes).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid_i  in  1  EXU presents a memory operation.
- in_ready_o  out  1  LSU can accept a new operation.
- lsop_i  in  4  operation: [3] we, [2] unsigned, [1:0] size (0=B, 1=H, 2=W, 3=D).
- addr_i  in  64  effective address from EXU.
- wdata_i  in  64  store data from EXU (low bytes significant).
- mem_req_o  out  1  memory request valid.
- mem_gnt_i  in  1  memory accepts the request this cycle.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  64  8-byte-aligned address.
- mem_wmask_o  out  8  byte-lane write mask.
- mem_wdata_o  out  64  lane-shifted write data.
- mem_rvalid_i  in  1  response (load data or store ack) valid.
- mem_rdata_i  in  64  raw 64-bit read data.
- out_valid_o  out  1  result available to writeback.
- out_ready_i  in  1  writeback consumes the result.
- out_data_o  out  64  extended load data; 0 for stores.
- misalign_o  out  1  qualifies out_valid_o; the access was misaligned.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - in_ready_o=1.
  - mem_req_o, mem_we_o, out_valid_o and misalign_o are 0.
  - mem_addr_o, mem_wdata_o, mem_wmask_o and out_data_o are 0.
  - Any in-flight transaction is abandoned; late mem_rvalid_i is ignored while in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE. All outputs are registered or decoded from state only; there is no combinational path from in_valid_i to mem_req_o.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i, latch lsop, addr and wdata.
  - Compute misalignment as (addr & (2^size - 1)) != 0.
  - If misaligned: go to DONE with misalign=1 and data=0; no memory request is issued.
  - Otherwise go to REQ.
- REQ:
  - mem_req_o=1; address, we, mask and wdata are held stable until grant.
  - mem_addr_o = addr with bits [2:0] cleared.
  - mem_wmask_o = (size mask: 0x01, 0x03, 0x0F or 0xFF) << addr[2:0]; the mask is 0 for loads.
  - mem_wdata_o = wdata << (8*addr[2:0]).
  - On mem_gnt_i: if mem_rvalid_i is also high that cycle, go to DONE; otherwise go to WAIT.
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i, capture the result and go to DONE.
- Load extraction:
  - raw = mem_rdata_i >> (8*addr[2:0]).
  - Truncate raw to the access size.
  - Zero-extend if lsop[2]=1, else sign-extend from the top bit of the access size.
  - Stores return 0.
- DONE:
  - out_valid_o=1; out_data_o and misalign_o are held.
  - On out_ready_i, go to IDLE the next cycle; out_valid_o drops.
  - No new request is accepted until IDLE (one outstanding transaction).
- Latency, with mem_gnt_i and mem_rvalid_i in the same cycle as the request and out_ready_i=1:
  - Accept in cycle 0, request in cycle 1, out_valid_o in cycle 2, in_ready_o back in cycle 3.
  - Misaligned access: accept in cycle 0, out_valid_o in cycle 1.
- lsop_i is don't-care when in_valid_i=0.
- Size 3 with unsigned=1 behaves as a plain 64-bit load.

Decomposition:
- Shared package/define file holds:
  - lsop field positions.
  - Size encodings (LS_B, LS_H, LS_W, LS_D).
  - FSM state encodings.
- One natural sub-module, ysyx_22040895_lsu_align. It is purely combinational and performs:
  - store mask/data shifting;
  - load shift/extension;
  - the misalignment check.
- The FSM and registers stay in ysyx_22040895_lsu.

Test Plan:
- LD, D, addr=0x80000010, rdata=0x1122334455667788 -> mem_addr=0x80000010; out_data=0x1122334455667788; misalign=0; out_valid in cycle 2.
- LB, then LBU, addr=0x80000005, rdata=0x0000_8000_0000_0000:
  - LB -> 0xFFFFFFFFFFFFFF80.
  - LBU -> 0x0000000000000080.
- SH, addr=0x80000006, wdata=0xABCD -> mem_addr=0x80000000; wmask=0xC0; wdata=0xABCD000000000000; we=1; out_data=0.
- LW, addr=0x80000002 -> no mem_req_o ever asserted; out_valid=1 and misalign=1 in cycle 1; out_data=0.
- Grant delayed 3 cycles, rvalid 2 cycles later, out_ready low for 4 cycles:
  - mem_req/addr/wmask stable until grant.
  - out_valid and out_data held for the full backpressure window.
  - in_ready=0 throughout.
- rst asserted in WAIT, then mem_rvalid_i pulses -> next cycle state=IDLE with all outputs at reset values; the stale response produces no out_valid.

Source files
------------

// File: rtl/ysyx_22040895_lsu_pkg.sv
// Shared definitions for the load/store unit: lsop field layout, access sizes,
// FSM states and the byte-lane mask helpers used by the align logic.
package ysyx_22040895_lsu_pkg;

  localparam int LSOP_WE    = 3;
  localparam int LSOP_UNS   = 2;
  localparam int LSOP_SZ_HI = 1;
  localparam int LSOP_SZ_LO = 0;

  typedef enum logic [1:0] {
    LS_B = 2'd0,
    LS_H = 2'd1,
    LS_W = 2'd2,
    LS_D = 2'd3
  } ls_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (ls_size_e'(size))
      LS_B:    m = 8'h01;
      LS_H:    m = 8'h03;
      LS_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] low_mask(input logic [1:0] size);
    logic [2:0] m;
    case (ls_size_e'(size))
      LS_B:    m = 3'b000;
      LS_H:    m = 3'b001;
      LS_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22040895_lsu_if.sv
// 64-bit data-memory bus: request/grant for the command, rvalid for the
// response (load data or store acknowledge).
interface ysyx_22040895_lsu_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  req;
  logic                  gnt;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   wmask;
  logic [DATA_W-1:0]     wdata;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, we, addr, wmask, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wmask, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ysyx_22040895_lsu_align.sv
// Combinational lane logic: misalignment check on the incoming request, store
// mask/data placement and load extraction for the latched request.
module ysyx_22040895_lsu_align
  import ysyx_22040895_lsu_pkg::*;
(
  input  logic [1:0]  chk_size,
  input  logic [2:0]  chk_off,
  output logic        misalign,
  input  logic [3:0]  lsop,
  input  logic [2:0]  off,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_sh,
  output logic [63:0] ld_data
);

  logic [63:0] raw;
  logic        uns;

  assign misalign = (chk_off & low_mask(chk_size)) != 3'b000;
  assign wmask    = lsop[LSOP_WE] ? (size_mask(lsop[LSOP_SZ_HI:LSOP_SZ_LO]) << off) : 8'h00;
  assign wdata_sh = wdata << {off, 3'b000};
  assign raw      = rdata >> {off, 3'b000};
  assign uns      = lsop[LSOP_UNS];

  // Truncate to the access size, then zero- or sign-extend; stores return 0.
  always_comb begin
    ld_data = raw;
    case (ls_size_e'(lsop[LSOP_SZ_HI:LSOP_SZ_LO]))
      LS_B:    ld_data = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      LS_H:    ld_data = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      LS_W:    ld_data = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: ld_data = raw;
    endcase
    if (lsop[LSOP_WE]) ld_data = '0;
  end

endmodule

// File: rtl/ysyx_22040895_lsu.sv
// Multi-cycle load/store unit: accepts one EXU memory op at a time, runs one
// 64-bit bus transaction and hands the extended result to writeback.
module ysyx_22040895_lsu
  import ysyx_22040895_lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [3:0]          lsop_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  ysyx_22040895_lsu_if.master mem,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W-1:0]   out_data_o,
  output logic                misalign_o
);

  lsu_state_e          state_q, state_d;
  logic [3:0]          lsop_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   data_q;
  logic                mis_q;

  logic                accept;
  logic                capture;
  logic                chk_mis;
  logic [7:0]          st_wmask;
  logic [DATA_W-1:0]   st_wdata;
  logic [DATA_W-1:0]   ld_data;

  ysyx_22040895_lsu_align u_align (
    .chk_size (lsop_i[LSOP_SZ_HI:LSOP_SZ_LO]),
    .chk_off  (addr_i[2:0]),
    .misalign (chk_mis),
    .lsop     (lsop_q),
    .off      (addr_q[2:0]),
    .wdata    (wdata_q),
    .rdata    (mem.rdata),
    .wmask    (st_wmask),
    .wdata_sh (st_wdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Misaligned ops skip the bus entirely; a response arriving with the grant
  // goes straight to DONE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          accept  = 1'b1;
          state_d = chk_mis ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem.gnt) begin
          capture = mem.rvalid;
          state_d = mem.rvalid ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (mem.rvalid) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lsop_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        lsop_q  <= lsop_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        data_q  <= '0;
        mis_q   <= chk_mis;
      end
      if (capture) begin
        data_q <= ld_data;
        mis_q  <= 1'b0;
      end
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign mem.req     = (state_q == REQ);
  assign mem.we      = (state_q == REQ) && lsop_q[LSOP_WE];
  assign mem.addr    = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem.wmask   = st_wmask;
  assign mem.wdata   = st_wdata;
  assign out_valid_o = (state_q == DONE);
  assign out_data_o  = data_q;
  assign misalign_o  = mis_q;

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// Randomized bench for the LSU: byte-addressed memory model plus a bus
// responder with random grant/response latency and random writeback stalls.
module tb_ysyx_22040895_lsu;

  typedef struct packed {
    logic [3:0]  lsop;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] data;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  lsop = 4'h0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        misalign;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        exp_q[$];
  int          head = 0;
  logic [7:0]  mdl_mem [logic [63:0]];
  logic [7:0]  rsp_mem [logic [63:0]];
  int          gnt_dly = 0;
  int          rv_dly = 0;
  int          ready_mode = 0;
  logic        force_en = 1'b0;
  logic [63:0] force_rdata = '0;

  ysyx_22040895_lsu_if mem_bus ();

  ysyx_22040895_lsu dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .lsop_i      (lsop),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .mem         (mem_bus),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .misalign_o  (misalign)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] bgByte(input logic [63:0] a);
    logic [63:0] t;
    t = a * 64'd29;
    return t[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [63:0] readWord(input logic [63:0] base);
    logic [63:0] w;
    w = '0;
    if (force_en) return force_rdata;
    for (int i = 0; i < 8; i++)
      w[8*i +: 8] = rsp_mem.exists(base + 64'(i)) ? rsp_mem[base + 64'(i)] : bgByte(base + 64'(i));
    return w;
  endfunction

  // Reference: byte-addressed memory, natural-alignment rule, little-endian
  // assembly and arithmetic sign extension.
  task automatic modelOp(input logic [3:0] op, input logic [63:0] a, input logic [63:0] wd,
                         output exp_t e);
    int n;
    logic [63:0] v;
    logic [7:0]  b;
    n = 1 << op[1:0];
    e.lsop  = op;
    e.addr  = a;
    e.wdata = wd;
    e.data  = '0;
    e.mis   = (a % 64'(n)) != 0;
    if (!e.mis) begin
      if (op[3]) begin
        for (int i = 0; i < n; i++) mdl_mem[a + 64'(i)] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) begin
          b = mdl_mem.exists(a + 64'(i)) ? mdl_mem[a + 64'(i)] : bgByte(a + 64'(i));
          v = v | (64'(b) << (8*i));
        end
        if (!op[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        e.data = v;
      end
    end
  endtask

  // lit_mode: 0 = model only, 1 = model pinned against literal, 2 = literal only
  task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] wd,
                               input int lit_mode, input logic [63:0] lit);
    exp_t e;
    logic accepted;
    modelOp(op, a, wd, e);
    if (lit_mode == 1) checkOutput("model_pin", e.data, lit);
    if (lit_mode != 0) e.data = lit;
    @(posedge clk); #1;
    in_valid = 1'b1;
    lsop     = op;
    addr     = a;
    wdata    = wd;
    accepted = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if (accepted) exp_q.push_back(e);
    in_valid = 1'b0;
    lsop     = 4'($urandom);
    addr     = {$urandom, $urandom};
    wdata    = {$urandom, $urandom};
  endtask

  task automatic waitIdle();
    for (int c = 0; c < 300; c++) begin
      if (head == exp_q.size()) break;
      @(negedge clk);
    end
    checkOutput("drain", 64'(head), 64'(exp_q.size()));
  endtask

  task automatic checkResetValues();
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_req", 64'(mem_bus.req), 64'd0);
    checkOutput("rst_we", 64'(mem_bus.we), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_misalign", 64'(misalign), 64'd0);
    checkOutput("rst_addr", mem_bus.addr, 64'd0);
    checkOutput("rst_wdata", mem_bus.wdata, 64'd0);
    checkOutput("rst_wmask", 64'(mem_bus.wmask), 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
  endtask

  // Bus responder: grants after gnt_dly request cycles, answers rv_dly cycles
  // after the grant (negative delay = random 0..3).
  initial begin
    logic        waiting;
    logic        pend;
    int          gcnt;
    int          rcnt;
    int          d;
    logic [63:0] paddr;
    waiting = 1'b0;
    pend    = 1'b0;
    gcnt    = 0;
    rcnt    = 0;
    paddr   = '0;
    mem_bus.gnt    = 1'b0;
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata  = '0;
    forever begin
      @(posedge clk); #2;
      mem_bus.gnt    = 1'b0;
      mem_bus.rvalid = 1'b0;
      mem_bus.rdata  = '0;
      if (rst) waiting = 1'b0;
      if (pend) begin
        if (rcnt == 0) begin
          mem_bus.rvalid = 1'b1;
          mem_bus.rdata  = readWord(paddr);
          pend = 1'b0;
        end else rcnt--;
      end else if (mem_bus.req && !rst) begin
        if (!waiting) begin
          waiting = 1'b1;
          gcnt = (gnt_dly < 0) ? int'($urandom_range(0, 3)) : gnt_dly;
        end
        if (gcnt == 0) begin
          mem_bus.gnt = 1'b1;
          waiting = 1'b0;
          if (mem_bus.we)
            for (int i = 0; i < 8; i++)
              if (mem_bus.wmask[i]) rsp_mem[mem_bus.addr + 64'(i)] = mem_bus.wdata[8*i +: 8];
          d = (rv_dly < 0) ? int'($urandom_range(0, 3)) : rv_dly;
          if (d == 0) begin
            mem_bus.rvalid = 1'b1;
            mem_bus.rdata  = readWord(mem_bus.addr);
          end else begin
            pend  = 1'b1;
            rcnt  = d - 1;
            paddr = mem_bus.addr;
          end
        end else gcnt--;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #3;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Every cycle: the in-flight op's bus command and result must match the model.
  initial begin
    exp_t       cur;
    logic       granted;
    int         off;
    int         n;
    logic [7:0] m;
    granted = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        head    = exp_q.size();
        granted = 1'b0;
      end else if (head < exp_q.size()) begin
        cur = exp_q[head];
        checkOutput("busy_in_ready", 64'(in_ready), 64'd0);
        if (cur.mis) checkOutput("misaligned_req", 64'(mem_bus.req), 64'd0);
        if (mem_bus.req && !cur.mis) begin
          off = int'(cur.addr[2:0]);
          n   = 1 << cur.lsop[1:0];
          m   = '0;
          if (cur.lsop[3]) for (int i = 0; i < n; i++) m[off+i] = 1'b1;
          checkOutput("req_after_gnt", 64'(granted), 64'd0);
          checkOutput("mem_addr", mem_bus.addr, {cur.addr[63:3], 3'b000});
          checkOutput("mem_we", 64'(mem_bus.we), 64'(cur.lsop[3]));
          checkOutput("mem_wmask", 64'(mem_bus.wmask), 64'(m));
          checkOutput("mem_wdata", mem_bus.wdata, cur.wdata << (8*off));
          if (mem_bus.gnt) granted = 1'b1;
        end
        if (out_valid) begin
          checkOutput("out_data", out_data, cur.data);
          checkOutput("out_misalign", 64'(misalign), 64'(cur.mis));
          if (out_ready) begin
            head++;
            granted = 1'b0;
          end
        end
      end else begin
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
        checkOutput("idle_out_valid", 64'(out_valid), 64'd0);
        checkOutput("idle_req", 64'(mem_bus.req), 64'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] held;
    int          req_cycles;
    logic        seen;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetValues();

    // Plain aligned doubleword load with single-cycle memory.
    force_en = 1'b1;
    force_rdata = 64'h1122334455667788;
    applyStimulus(4'b0011, 64'h80000010, 64'd0, 2, 64'h1122334455667788);
    @(negedge clk);
    checkOutput("ld_c1_req", 64'(mem_bus.req), 64'd1);
    checkOutput("ld_c1_valid", 64'(out_valid), 64'd0);
    checkOutput("ld_c1_addr", mem_bus.addr, 64'h80000010);
    @(negedge clk);
    checkOutput("ld_c2_valid", 64'(out_valid), 64'd1);
    checkOutput("ld_c2_data", out_data, 64'h1122334455667788);
    checkOutput("ld_c2_mis", 64'(misalign), 64'd0);
    @(negedge clk);
    checkOutput("ld_c3_ready", 64'(in_ready), 64'd1);

    force_rdata = 64'h0000800000000000;
    applyStimulus(4'b0000, 64'h80000005, 64'd0, 2, 64'hFFFFFFFFFFFFFF80);
    waitIdle();
    applyStimulus(4'b0100, 64'h80000005, 64'd0, 2, 64'h0000000000000080);
    waitIdle();
    force_en = 1'b0;

    // Halfword store into the top lanes, then read it back several ways.
    applyStimulus(4'b1001, 64'h80000006, 64'h000000000000ABCD, 1, 64'd0);
    @(negedge clk);
    checkOutput("sh_req", 64'(mem_bus.req), 64'd1);
    checkOutput("sh_addr", mem_bus.addr, 64'h80000000);
    checkOutput("sh_wmask", 64'(mem_bus.wmask), 64'hC0);
    checkOutput("sh_wdata", mem_bus.wdata, 64'hABCD000000000000);
    checkOutput("sh_we", 64'(mem_bus.we), 64'd1);
    waitIdle();
    applyStimulus(4'b0001, 64'h80000006, 64'd0, 1, 64'hFFFFFFFFFFFFABCD);
    waitIdle();
    applyStimulus(4'b0101, 64'h80000006, 64'd0, 1, 64'h000000000000ABCD);
    waitIdle();
    applyStimulus(4'b0100, 64'h80000007, 64'd0, 1, 64'h00000000000000AB);
    waitIdle();
    applyStimulus(4'b0000, 64'h80000006, 64'd0, 1, 64'hFFFFFFFFFFFFFFCD);
    waitIdle();

    // Misaligned word load never reaches the bus.
    applyStimulus(4'b0010, 64'h80000002, 64'd0, 1, 64'd0);
    @(negedge clk);
    checkOutput("mis_valid", 64'(out_valid), 64'd1);
    checkOutput("mis_flag", 64'(misalign), 64'd1);
    checkOutput("mis_data", out_data, 64'd0);
    checkOutput("mis_req", 64'(mem_bus.req), 64'd0);
    waitIdle();

    // Slow grant, slow response and a stalled writeback.
    gnt_dly = 3;
    rv_dly  = 2;
    ready_mode = 2;
    applyStimulus(4'b0010, 64'h80001004, 64'd0, 0, 64'd0);
    req_cycles = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_bus.req) begin
        req_cycles++;
        checkOutput("bp_addr", mem_bus.addr, 64'h80001000);
        checkOutput("bp_wmask", 64'(mem_bus.wmask), 64'd0);
      end
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("bp_req_cycles", 64'(req_cycles), 64'd4);
    checkOutput("bp_seen", 64'(seen), 64'd1);
    held = out_data;
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_data", out_data, held);
      checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    ready_mode = 0;
    waitIdle();

    // Reset while waiting for the response; the late rvalid must be ignored.
    gnt_dly = 0;
    rv_dly  = 3;
    applyStimulus(4'b0011, 64'h80001020, 64'd0, 0, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("wait_req", 64'(mem_bus.req), 64'd0);
    checkOutput("wait_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetValues();
    repeat (4) begin
      @(negedge clk);
      checkOutput("stale_valid", 64'(out_valid), 64'd0);
      checkOutput("stale_in_ready", 64'(in_ready), 64'd1);
    end

    // Random traffic over a small window so stores and loads overlap.
    gnt_dly = -1;
    rv_dly  = -1;
    ready_mode = 1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      applyStimulus(4'($urandom), 64'h80001000 + 64'($urandom_range(0, 63)),
                    {$urandom, $urandom}, 0, 64'd0);
    end
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
